button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
- Memory-mapped controller for the board push-buttons on the single-cycle RISC-V CPU's IO bus.
- Synchronises and debounces each raw button, presents the debounced level word, and latches press events into sticky pending bits.
- Pending bits are write-1-to-clear and drive a maskable level interrupt, so software no longer has to poll raw button levels.

Parameters:
- NUM_BTN, 5, number of buttons; legal range 1..16.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles needed to accept a level change (10 ms at 100 MHz); minimum 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  NUM_BTN  raw, asynchronous button inputs; 1 = pressed.
- wr_en  input  1  bus write strobe, one cycle per write.
- addr  input  4  byte offset; bits [3:2] select the register, bits [1:0] are ignored.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational from addr.
- irq  output  1  registered interrupt request, level-high.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - synchroniser flops, debounced levels, counters, pending bits, IRQ_EN and irq are all 0;
  - every per-button FSM is in S0.
- Synchroniser: two flops per button. btn_sync is btn_raw delayed by 2 cycles.
- Per-button FSM, with states S0 (stable low), C1 (checking high), S1 (stable high) and C0 (checking low):
  - S0: if btn_sync = 1, go to C1 and clear the counter.
  - C1: if btn_sync = 0, return to S0.
  - C1: otherwise increment the counter. When counter = DEBOUNCE_CYCLES-1, go to S1, set level = 1 and raise a one-cycle press pulse.
  - S1 and C0 mirror S0 and C1. Reaching S0 from C0 sets level = 0 and raises a one-cycle release pulse.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no level change and no pulse.
- Latency from a clean edge on btn_raw to the level/pending update: 2 + DEBOUNCE_CYCLES cycles.
- The counter saturates. It never wraps, because it is cleared on every state entry.
- Register map:
  - 0x0 LEVEL, read-only: {ones in bits [31:NUM_BTN], level[NUM_BTN-1:0]}. Upper bits read 1 for software compatibility with the existing button word format.
  - 0x4 PRESS_PEND: reads {zeros, press_pend}. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x8 IRQ_EN: read/write, bits [NUM_BTN-1:0]; all other bits read 0.
  - 0xC RELEASE_PEND: see Optional Feature.
- A write to a read-only register or a read-only bit is ignored. Reads have no side effects.
- A press pulse in the same cycle as a W1C of that bit: the bit stays 1 (set wins).
- irq is registered: irq <= |(press_pend & irq_en), plus release terms when the option is enabled. irq therefore follows a pending change by 1 cycle.
- Assertion of rst_n mid-debounce aborts the check. No event is generated afterwards, even if the button is still held. A button held through reset is accepted as a new press DEBOUNCE_CYCLES+2 cycles after rst_n deasserts.

Optional Feature:
- Macro: BTN_RELEASE_EVT_EN.
- When defined:
  - a release_pend[NUM_BTN-1:0] register sits at 0xC, set by release pulses and W1C, with the same set-wins rule;
  - IRQ_EN bits [16+NUM_BTN-1:16] enable release interrupts;
  - irq also ORs in |(release_pend & irq_en[16+:NUM_BTN]).
- When undefined:
  - no release register exists; 0xC reads 0 and writes are ignored;
  - IRQ_EN bits [31:16] read 0;
  - release pulses are left unconnected.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, NUM_BTN = 5.
- Reset: rst_n = 0, then release; read 0x0 -> 0xFFFFFFE0; read 0x4 -> 0; irq = 0.
- Clean press: btn_raw[2] 0->1 held 10 cycles -> LEVEL bit 2 rises exactly 6 cycles after the edge; PRESS_PEND = 0x04; with IRQ_EN = 0x04, irq = 1 one cycle later.
- Glitch rejection: btn_raw[0] high for 3 cycles then low -> LEVEL stays 0xFFFFFFE0, PRESS_PEND stays 0.
- W1C and collision: PRESS_PEND = 0x05; write 0x04 to 0x4 -> reads 0x01. Then write 0x01 in the same cycle as a new press of button 0 -> reads 0x01 and irq stays high.
- Reset mid-debounce: hold btn_raw[4] = 1 and pulse rst_n low during C1 -> no pending bit before reset; PRESS_PEND = 0x10 exactly 6 cycles after rst_n rises.
- BTN_RELEASE_EVT_EN defined: press then release button 1 -> 0xC reads 0x02, and irq rises only when IRQ_EN bit 17 = 1. With the macro undefined, 0xC reads 0.

Source files
------------

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Memory-mapped push-button controller for the CPU IO bus. Each raw button is
// passed through a two-flop synchroniser and a per-button debounce FSM. The
// debounced levels are readable, press edges set sticky write-1-to-clear
// pending bits, and the pending bits drive a maskable level interrupt.
//
// Register map (addr[3:2] selects, addr[1:0] ignored):
//   0x0 LEVEL        RO   {ones above NUM_BTN, level[NUM_BTN-1:0]}
//   0x4 PRESS_PEND   W1C  {zeros, press_pend[NUM_BTN-1:0]}
//   0x8 IRQ_EN       RW   press enables in [NUM_BTN-1:0],
//                         release enables in [16+NUM_BTN-1:16] (option only)
//   0xC RELEASE_PEND W1C  {zeros, release_pend} (option only, else reads 0)
//
// Optional feature macro: BTN_RELEASE_EVT_EN
//   Defined   -> release pending register, release interrupt enables.
//   Undefined -> 0xC reads 0, IRQ_EN[31:16] reads 0, release pulses unused.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   btn_raw  raw asynchronous button inputs, 1 = pressed
//   wr_en    bus write strobe, one cycle per write
//   addr     byte offset of the register
//   wdata    write data
//   rdata    read data, combinational from addr
//   irq      registered level-high interrupt request
// -----------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               wr_en,
  input  logic [3:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (NUM_BTN < 1 || NUM_BTN > 16) begin : g_bad_num_btn
    $error("button_event_ctrl: NUM_BTN must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_event_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("button_event_ctrl: 2**CNT_W must exceed DEBOUNCE_CYCLES");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S0 = 2'd0,  // stable low
    C1 = 2'd1,  // checking high
    S1 = 2'd2,  // stable high
    C0 = 2'd3   // checking low
  } btn_state_e;

  typedef enum logic [1:0] {
    REG_LEVEL   = 2'd0,
    REG_PRESS   = 2'd1,
    REG_IRQ_EN  = 2'd2,
    REG_RELEASE = 2'd3
  } reg_sel_e;

  localparam logic [31:0] BTN_MASK = (32'h1 << NUM_BTN) - 32'h1;
`ifdef BTN_RELEASE_EVT_EN
  localparam logic [31:0] IRQ_EN_MASK = BTN_MASK | (BTN_MASK << 16);
`else
  localparam logic [31:0] IRQ_EN_MASK = BTN_MASK;
`endif

  // The counter is cleared on entry to a checking state and the sample that
  // entered it is the first stable one. Accepting when the counter is about to
  // step to DEBOUNCE_CYCLES-1 means exactly DEBOUNCE_CYCLES stable samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] btn_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = sync2_q;

  // ---------------------------------------------------------------------------
  // Per-button debounce FSMs
  // ---------------------------------------------------------------------------
  btn_state_e         state_q [NUM_BTN];
  btn_state_e         state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] press_evt;
  logic [NUM_BTN-1:0] release_evt;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      level_d[i]     = level_q[i];
      press_evt[i]   = 1'b0;
      release_evt[i] = 1'b0;

      unique case (state_q[i])
        S0: begin
          if (btn_sync[i]) begin
            state_d[i] = C1;
            cnt_d[i]   = '0;
          end
        end
        C1: begin
          if (!btn_sync[i]) begin
            state_d[i] = S0;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = S1;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b1;
            press_evt[i] = 1'b1;
          end else if (cnt_q[i] != '1) begin
            // Saturating increment; unreachable wrap is still guarded.
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S1: begin
          if (!btn_sync[i]) begin
            state_d[i] = C0;
            cnt_d[i]   = '0;
          end
        end
        C0: begin
          if (btn_sync[i]) begin
            state_d[i] = S1;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]     = S0;
            cnt_d[i]       = '0;
            level_d[i]     = 1'b0;
            release_evt[i] = 1'b1;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S0;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // NOTE: the per-button state and counter arrays are reset explicitly; a
  // reset mid-debounce must abort any check in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= S0;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: pending bits, interrupt enables, interrupt
  // ---------------------------------------------------------------------------
  reg_sel_e           reg_sel;
  logic               wr_press;
  logic               wr_irq_en;
  logic [NUM_BTN-1:0] press_pend_q;
  logic [NUM_BTN-1:0] press_pend_d;
  logic [31:0]        irq_en_q;
  logic [31:0]        irq_en_d;
  logic               irq_q;
  logic               irq_d;

  assign reg_sel   = reg_sel_e'(addr[3:2]);
  assign wr_press  = wr_en && (reg_sel == REG_PRESS);
  assign wr_irq_en = wr_en && (reg_sel == REG_IRQ_EN);

`ifdef BTN_RELEASE_EVT_EN
  logic               wr_release;
  logic [NUM_BTN-1:0] release_pend_q;
  logic [NUM_BTN-1:0] release_pend_d;

  assign wr_release = wr_en && (reg_sel == REG_RELEASE);
`endif

  always_comb begin
    // Clear first, then set: a pulse coincident with a W1C keeps the bit set.
    press_pend_d = (press_pend_q & ~(wr_press ? wdata[NUM_BTN-1:0] : '0))
                 | press_evt;
    irq_en_d     = wr_irq_en ? (wdata & IRQ_EN_MASK) : irq_en_q;
    irq_d        = |(press_pend_q & irq_en_q[NUM_BTN-1:0]);
`ifdef BTN_RELEASE_EVT_EN
    release_pend_d = (release_pend_q & ~(wr_release ? wdata[NUM_BTN-1:0] : '0))
                   | release_evt;
    irq_d          = irq_d | (|(release_pend_q & irq_en_q[16 +: NUM_BTN]));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend_q <= '0;
      irq_en_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      press_pend_q <= press_pend_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_pend_q <= '0;
    end else begin
      release_pend_q <= release_pend_d;
    end
  end
`endif

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_LEVEL: begin
        // Upper bits read as ones to keep the legacy button word format.
        rdata                = ~BTN_MASK;
        rdata[NUM_BTN-1:0]   = level_q;
      end
      REG_PRESS: begin
        rdata[NUM_BTN-1:0]   = press_pend_q;
      end
      REG_IRQ_EN: begin
        rdata                = irq_en_q;
      end
      REG_RELEASE: begin
`ifdef BTN_RELEASE_EVT_EN
        rdata[NUM_BTN-1:0]   = release_pend_q;
`else
        rdata                = '0;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // Bits that are intentionally not used by the logic above.
  logic unused_bits;
`ifdef BTN_RELEASE_EVT_EN
  assign unused_bits = ^addr[1:0];
`else
  assign unused_bits = ^{addr[1:0], release_evt};
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
//
// Bench for button_event_ctrl with NUM_BTN = 5, DEBOUNCE_CYCLES = 4. A table
// of register accesses checks the map after reset, hand-written sequences cover
// press latency, glitches, W1C collisions, reset mid-debounce and the release
// option, and a randomized phase compares against a run-length reference.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam logic [31:0] LVL_IDLE = 32'hFFFF_FFE0;
`ifdef BTN_RELEASE_EVT_EN
  localparam logic [31:0] EN_MASK = 32'h001F_001F;
`else
  localparam logic [31:0] EN_MASK = 32'h0000_001F;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          wr_en = 1'b0;
  logic [3:0]    addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;

  button_event_ctrl #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .wr_en  (wr_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a button's accepted level flips once the synchronised
  // input has disagreed with it for DEB consecutive samples.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] m_level, m_press, m_rel;
  logic [31:0]   m_en;
  logic          m_irq;
  int            m_run [NB];
  logic [NB-1:0] m_hist [$];

  task automatic model_reset();
    m_level = '0; m_press = '0; m_rel = '0; m_en = '0; m_irq = 1'b0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_hist = {};
    m_hist.push_back('0);
    m_hist.push_back('0);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic [NB-1:0] s, pev, rev, clr_p, clr_r;
    logic          irq_next;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(btn_raw);
    irq_next = |(m_press & m_en[NB-1:0]);
`ifdef BTN_RELEASE_EVT_EN
    irq_next = irq_next | (|(m_rel & m_en[16 +: NB]));
`endif
    pev = '0; rev = '0;
    for (int i = 0; i < NB; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          if (s[i]) pev[i] = 1'b1;
          else      rev[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    clr_p = (wr_en && addr[3:2] == 2'd1) ? wdata[NB-1:0] : '0;
    clr_r = (wr_en && addr[3:2] == 2'd3) ? wdata[NB-1:0] : '0;
    m_press = (m_press & ~clr_p) | pev;
`ifdef BTN_RELEASE_EVT_EN
    m_rel = (m_rel & ~clr_r) | rev;
`else
    m_rel = '0;
    if (clr_r != '0 && rev != '0) m_rel = '0;
`endif
    if (wr_en && addr[3:2] == 2'd2) m_en = wdata & EN_MASK;
    m_irq = irq_next;
  endtask

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return LVL_IDLE | 32'(m_level);
      2'd1:    return 32'(m_press);
      2'd2:    return m_en;
`ifdef BTN_RELEASE_EVT_EN
      default: return 32'(m_rel);
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_raw = '0; wr_en = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];
  int   hold [NB];

  initial begin
    // Register-map table, applied straight after reset.
    vecs[0]  = '{1'b0, 4'h0, 32'h0,         LVL_IDLE};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 4'h8, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h0,         LVL_IDLE};
    vecs[5]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, EN_MASK};
    vecs[7]  = '{1'b0, 4'hB, 32'h0,         EN_MASK};
    vecs[8]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b1, 4'h8, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 4'h3, 32'h0,         LVL_IDLE};

    do_reset();
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      tick();
    end

    // Clean press of button 2: level rises on the 6th edge, irq one later.
    bus_write(4'h8, 32'h04);
    btn_raw[2] = 1'b1;
    repeat (5) tick();
    check_read("press_level_early", 4'h0, LVL_IDLE);
    tick();
    check_read("press_level", 4'h0, 32'hFFFF_FFE4);
    check_read("press_pend", 4'h4, 32'h04);
    check("press_irq_early", {31'b0, irq}, 32'h0);
    tick();
    check("press_irq", {31'b0, irq}, 32'h1);
    repeat (3) tick();
    btn_raw[2] = 1'b0;
    repeat (8) tick();
    check_read("release_level", 4'h0, LVL_IDLE);
    bus_write(4'h4, 32'h1F);

    // Glitch of three cycles on button 0 is rejected.
    btn_raw[0] = 1'b1;
    repeat (3) tick();
    btn_raw[0] = 1'b0;
    repeat (8) tick();
    check_read("glitch_level", 4'h0, LVL_IDLE);
    check_read("glitch_pend", 4'h4, 32'h0);

    // W1C and set-wins collision.
    btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
    repeat (8) tick();
    check_read("two_pend", 4'h4, 32'h05);
    btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
    repeat (8) tick();
    bus_write(4'h4, 32'h04);
    check_read("w1c_partial", 4'h4, 32'h01);
    bus_write(4'h8, 32'h01);
    repeat (2) tick();
    check("w1c_irq_before", {31'b0, irq}, 32'h1);
    btn_raw[0] = 1'b1;
    repeat (5) tick();
    check_read("collide_level_early", 4'h0, LVL_IDLE);
    wr_en = 1'b1; addr = 4'h4; wdata = 32'h01;
    tick();
    wr_en = 1'b0;
    check_read("collide_pend", 4'h4, 32'h01);
    check("collide_irq0", {31'b0, irq}, 32'h1);
    tick();
    check("collide_irq1", {31'b0, irq}, 32'h1);
    btn_raw[0] = 1'b0;
    repeat (8) tick();
    bus_write(4'h4, 32'h1F);

    // Reset in the middle of a debounce check on button 4.
    btn_raw[4] = 1'b1;
    repeat (4) tick();
    check_read("rstmid_pre", 4'h4, 32'h0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check_read("rstmid_during", 4'h4, 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    check_read("rstmid_early", 4'h4, 32'h0);
    tick();
    check_read("rstmid_pend", 4'h4, 32'h10);
    check_read("rstmid_en", 4'h8, 32'h0);
    btn_raw[4] = 1'b0;
    repeat (8) tick();
    bus_write(4'h4, 32'h1F);
    bus_write(4'h8, 32'h0);

    // Press and release of button 1 for the release-event register.
    btn_raw[1] = 1'b1;
    repeat (8) tick();
    btn_raw[1] = 1'b0;
    repeat (8) tick();
`ifdef BTN_RELEASE_EVT_EN
    check_read("rel_pend", 4'hC, 32'h02);
    check("rel_irq_off", {31'b0, irq}, 32'h0);
    bus_write(4'h8, 32'h0002_0000);
    check("rel_irq_early", {31'b0, irq}, 32'h0);
    tick();
    check("rel_irq_on", {31'b0, irq}, 32'h1);
    bus_write(4'hC, 32'h02);
    check_read("rel_w1c", 4'hC, 32'h0);
`else
    check_read("rel_absent", 4'hC, 32'h0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    check_read("rel_absent_wr", 4'hC, 32'h0);
    bus_write(4'h8, 32'hFFFF_FFFF);
    check_read("rel_en_hi_zero", 4'h8, 32'h1F);
`endif

    // Randomized phase against the reference model.
    do_reset();
    for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 7);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i]    = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      wr_en = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      #1;
      check("rand_rdata", rdata, m_rdata(addr));
      check("rand_irq", {31'b0, irq}, {31'b0, m_irq});
      tick();
    end
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
